polytomsg_masked_decode_rng_seed_feeder: RTL and testbench



---
 rtl/polytomsg_masked_decode_rng_seed_feeder.sv | 241 ++++++++++++++++++++++++
 tb/tb_polytomsg_masked_decode_rng_seed_feeder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/polytomsg_masked_decode_rng_seed_feeder.sv
// Seed sequencer for the masked-decode RNG core.
// Buffers 32-bit entropy words in a small FIFO, runs a repetition-count
// health test on every accepted word, and on a reseed request builds a
// 96-bit frame, pulses the core reset, streams six seed halfwords and
// finally flags the core as ready once its load latency has elapsed.
// Handshake: a word transfers at a posedge where ent_valid and ent_ready
// are both high; ent_ready is registered and only depends on FIFO fullness.
module polytomsg_masked_decode_rng_seed_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int RST_CYC    = 2,
    parameter int PRE_CYC    = 4,
    parameter int LOAD_LAT   = 4,
    parameter int REP_MAX    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ent_data,
    input  logic        ent_valid,
    output logic        ent_ready,
    input  logic        reseed_req,
    output logic        busy,
    output logic        rng_rst_n,
    output logic [15:0] seed,
    output logic        rng_ready,
    output logic        health_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_RESET   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_STREAM  = 3'd4;
    localparam logic [2:0] S_SETTLE  = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    localparam logic [7:0]  RST_LAST  = 8'(RST_CYC - 1);
    localparam logic [7:0]  PRE_LAST  = 8'(PRE_CYC - 1);
    localparam logic [7:0]  LOAD_LAST = 8'(LOAD_LAT - 1);
    localparam logic [7:0]  REP_LAST  = 8'(REP_MAX - 1);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   prev_q, prev_d;
    logic          prev_vld_q, prev_vld_d;
    logic [7:0]    rep_q, rep_d;
    logic [2:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [95:0]   frame_q, frame_d;
    logic          seeded_q, seeded_d;
    logic          ent_ready_q, ent_ready_d;
    logic          busy_q, busy_d;
    logic          rng_rst_n_q, rng_rst_n_d;
    logic [15:0]   seed_q, seed_d;
    logic          rng_ready_q, rng_ready_d;
    logic          health_err_q, health_err_d;
    logic          push, pop, trip;

    assign push = ent_valid & ent_ready_q;
    assign pop  = (state_q == S_COLLECT) && (count_q != '0);

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Repetition-count health test over consecutively accepted words
    always_comb begin
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        rep_d        = rep_q;
        trip         = 1'b0;
        if (push) begin
            prev_d     = ent_data;
            prev_vld_d = 1'b1;
            if (prev_vld_q && (ent_data == prev_q)) begin
                if (rep_q != REP_LAST) rep_d = rep_q + 8'd1;
            end else begin
                rep_d = 8'd0;
            end
            trip = (rep_d == REP_LAST);
        end
        health_err_d = health_err_q | trip;
    end

    // Sequencer FSM; a health trip overrides any transition
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        seeded_d = seeded_q;
        case (state_q)
            S_IDLE: begin
                if (reseed_req) begin
                    state_d = S_COLLECT;
                    idx_d   = 2'd0;
                end
            end
            S_COLLECT: begin
                if (pop) begin
                    frame_d = {frame_q[63:0], mem_q[rd_ptr_q]};
                    if (idx_q == 2'd2) begin
                        state_d = S_RESET;
                        cnt_d   = 8'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d  = S_WAIT;
                    cnt_d    = 8'd0;
                    seeded_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = S_STREAM;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_STREAM: begin
                if (cnt_q == 8'd5) begin
                    state_d = S_SETTLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
        if (trip) state_d = S_ERR;
    end

    // Output values for the next cycle, derived from the next state
    always_comb begin
        ent_ready_d = (count_d != FULL_CNT);
        busy_d      = (state_d == S_COLLECT) || (state_d == S_RESET) ||
                      (state_d == S_WAIT) || (state_d == S_STREAM) ||
                      (state_d == S_SETTLE);
        rng_rst_n_d = seeded_d && (state_d != S_RESET) && (state_d != S_ERR);
        seed_d      = 16'd0;
        if (state_d == S_STREAM) begin
            case (cnt_d)
                8'd0:    seed_d = frame_q[95:80];
                8'd1:    seed_d = frame_q[79:64];
                8'd2:    seed_d = frame_q[63:48];
                8'd3:    seed_d = frame_q[47:32];
                8'd4:    seed_d = frame_q[31:16];
                default: seed_d = frame_q[15:0];
            endcase
        end
        rng_ready_d = rng_ready_q;
        if (state_d == S_DONE) rng_ready_d = 1'b1;
        if ((state_d == S_COLLECT) || (state_d == S_ERR)) rng_ready_d = 1'b0;
    end

    // FIFO storage; contents need no reset since occupancy guards reads
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ent_data;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            prev_q       <= 32'd0;
            prev_vld_q   <= 1'b0;
            rep_q        <= 8'd0;
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            idx_q        <= 2'd0;
            frame_q      <= 96'd0;
            seeded_q     <= 1'b0;
            ent_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            rng_rst_n_q  <= 1'b0;
            seed_q       <= 16'd0;
            rng_ready_q  <= 1'b0;
            health_err_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            rep_q        <= rep_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            seeded_q     <= seeded_d;
            ent_ready_q  <= ent_ready_d;
            busy_q       <= busy_d;
            rng_rst_n_q  <= rng_rst_n_d;
            seed_q       <= seed_d;
            rng_ready_q  <= rng_ready_d;
            health_err_q <= health_err_d;
        end
    end

    assign ent_ready  = ent_ready_q;
    assign busy       = busy_q;
    assign rng_rst_n  = rng_rst_n_q;
    assign seed       = seed_q;
    assign rng_ready  = rng_ready_q;
    assign health_err = health_err_q;

endmodule

// File: tb/tb_polytomsg_masked_decode_rng_seed_feeder.sv
// Bench for the RNG seed feeder: a per-cycle vector table for full reseed
// sequences plus hand-written sequences for stalls, reset and health errors.
// Entry k of the table is driven before posedge k and checked 1 ns after it.
module tb_polytomsg_masked_decode_rng_seed_feeder;

    logic        clk;
    logic        rst;
    logic [31:0] ent_data;
    logic        ent_valid;
    logic        ent_ready;
    logic        reseed_req;
    logic        busy;
    logic        rng_rst_n;
    logic [15:0] seed;
    logic        rng_ready;
    logic        health_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        reseed;
        logic        push;
        logic [31:0] pdata;
        logic        er_chk;
        logic        er_exp;
        logic        busy;
        logic        rst_n;
        logic [15:0] seed;
        logic        ready;
    } vec_t;

    vec_t tbl[22];
    logic [15:0] exp_q[$];

    polytomsg_masked_decode_rng_seed_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .ent_data  (ent_data),
        .ent_valid (ent_valid),
        .ent_ready (ent_ready),
        .reseed_req(reseed_req),
        .busy      (busy),
        .rng_rst_n (rng_rst_n),
        .seed      (seed),
        .rng_ready (rng_ready),
        .health_err(health_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        ent_data  = d;
        ent_valid = 1'b1;
        tick();
        ent_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        chk({tag, " rst ent_ready"}, 32'(ent_ready), 32'd0);
        chk({tag, " rst busy"}, 32'(busy), 32'd0);
        chk({tag, " rst rng_rst_n"}, 32'(rng_rst_n), 32'd0);
        chk({tag, " rst seed"}, 32'(seed), 32'd0);
        chk({tag, " rst rng_ready"}, 32'(rng_ready), 32'd0);
        chk({tag, " rst health_err"}, 32'(health_err), 32'd0);
        rst = 1'b0;
        tick();
        chk({tag, " post-rst ent_ready"}, 32'(ent_ready), 32'd1);
    endtask

    // Expected per-cycle outputs for a reseed with three words already queued
    task automatic fill_table(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic seeded);
        logic [15:0] hw[6];
        hw[0] = w0[31:16]; hw[1] = w0[15:0];
        hw[2] = w1[31:16]; hw[3] = w1[15:0];
        hw[4] = w2[31:16]; hw[5] = w2[15:0];
        for (int k = 0; k < 22; k++) begin
            tbl[k].reseed = (k == 0);
            tbl[k].push   = 1'b0;
            tbl[k].pdata  = 32'd0;
            tbl[k].er_chk = 1'b0;
            tbl[k].er_exp = 1'b0;
            tbl[k].busy   = (k <= 18);
            tbl[k].ready  = (k >= 19);
            if (k == 3 || k == 4) tbl[k].rst_n = 1'b0;
            else                  tbl[k].rst_n = seeded ? 1'b1 : (k >= 5);
            tbl[k].seed = (k >= 9 && k <= 14) ? hw[k - 9] : 16'd0;
        end
    endtask

    task automatic apply_table(input string tag);
        for (int k = 0; k < 22; k++) begin
            reseed_req = tbl[k].reseed;
            ent_valid  = tbl[k].push;
            ent_data   = tbl[k].pdata;
            tick();
            reseed_req = 1'b0;
            ent_valid  = 1'b0;
            chk($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(tbl[k].busy));
            chk($sformatf("%s rng_rst_n k=%0d", tag, k), 32'(rng_rst_n), 32'(tbl[k].rst_n));
            chk($sformatf("%s seed k=%0d", tag, k), 32'(seed), 32'(tbl[k].seed));
            chk($sformatf("%s rng_ready k=%0d", tag, k), 32'(rng_ready), 32'(tbl[k].ready));
            if (tbl[k].er_chk)
                chk($sformatf("%s ent_ready k=%0d", tag, k), 32'(ent_ready), 32'(tbl[k].er_exp));
        end
    endtask

    initial begin
        rst        = 1'b1;
        ent_data   = 32'd0;
        ent_valid  = 1'b0;
        reseed_req = 1'b0;
        tick();

        // Reset values, then a basic reseed from a preloaded FIFO
        do_reset("t1");
        push_word(32'h1111_2222);
        push_word(32'h3333_4444);
        push_word(32'h5555_6666);
        fill_table(32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 1'b0);
        apply_table("t1");

        // Reseed from an empty FIFO, one word every third cycle
        begin
            logic [31:0] sw[3];
            sw[0] = 32'hA1A2_A3A4; sw[1] = 32'hB1B2_B3B4; sw[2] = 32'hC1C2_C3C4;
            for (int i = 0; i < 3; i++) begin
                exp_q.push_back(sw[i][31:16]);
                exp_q.push_back(sw[i][15:0]);
            end
            reseed_req = 1'b1;
            tick();
            reseed_req = 1'b0;
            chk("t2 busy n=0", 32'(busy), 32'd1);
            chk("t2 rng_ready cleared", 32'(rng_ready), 32'd0);
            for (int n = 1; n <= 27; n++) begin
                if (n == 2 || n == 5 || n == 8) begin
                    ent_valid = 1'b1;
                    ent_data  = sw[(n - 2) / 3];
                end
                tick();
                ent_valid = 1'b0;
                chk($sformatf("t2 busy n=%0d", n), 32'(busy), 32'(n <= 24));
                chk($sformatf("t2 rng_rst_n n=%0d", n), 32'(rng_rst_n), 32'(!(n == 9 || n == 10)));
                chk($sformatf("t2 rng_ready n=%0d", n), 32'(rng_ready), 32'(n >= 25));
                if (n >= 15 && n <= 20 && exp_q.size() > 0)
                    chk($sformatf("t2 seed n=%0d", n), 32'(seed), 32'(exp_q.pop_front()));
                else
                    chk($sformatf("t2 seed n=%0d", n), 32'(seed), 32'd0);
            end
        end

        // Fill to full, push while popping, reseed ignored during SETTLE
        begin
            logic [31:0] cw[4];
            cw[0] = 32'hC001_0001; cw[1] = 32'hC002_0002;
            cw[2] = 32'hC003_0003; cw[3] = 32'hC004_0004;
            for (int i = 0; i < 4; i++) begin
                push_word(cw[i]);
                chk($sformatf("t3 ent_ready after push %0d", i), 32'(ent_ready), 32'(i != 3));
            end
            fill_table(cw[0], cw[1], cw[2], 1'b1);
            tbl[0].er_chk = 1'b1; tbl[0].er_exp = 1'b0;
            tbl[2].push = 1'b1; tbl[2].pdata = 32'hD001_0001; tbl[2].er_chk = 1'b1; tbl[2].er_exp = 1'b1;
            tbl[3].push = 1'b1; tbl[3].pdata = 32'hD002_0002; tbl[3].er_chk = 1'b1; tbl[3].er_exp = 1'b1;
            tbl[4].push = 1'b1; tbl[4].pdata = 32'hD003_0003; tbl[4].er_chk = 1'b1; tbl[4].er_exp = 1'b0;
            tbl[17].reseed = 1'b1;
            apply_table("t3a");
            fill_table(cw[3], 32'hD001_0001, 32'hD002_0002, 1'b1);
            tbl[0].er_chk = 1'b1; tbl[0].er_exp = 1'b0;
            tbl[1].er_chk = 1'b1; tbl[1].er_exp = 1'b1;
            apply_table("t3b");
        end

        // Reset in the middle of STREAM discards everything, including FIFO
        push_word(32'hE001_0001);
        push_word(32'hE002_0002);
        push_word(32'hE003_0003);
        reseed_req = 1'b1;
        tick();
        reseed_req = 1'b0;
        for (int n = 1; n <= 11; n++) tick();
        chk("t5 seed mid-stream", 32'(seed), 32'h0000_E001);
        do_reset("t5");
        push_word(32'hF001_0001);
        push_word(32'hF002_0002);
        push_word(32'hF003_0003);
        fill_table(32'hF001_0001, 32'hF002_0002, 32'hF003_0003, 1'b0);
        apply_table("t5");

        // Repetition health test trips on the fourth identical word
        for (int i = 0; i < 4; i++) begin
            push_word(32'hDEAD_BEEF);
            chk($sformatf("t4 health_err push %0d", i), 32'(health_err), 32'(i == 3));
        end
        chk("t4 rng_rst_n in err", 32'(rng_rst_n), 32'd0);
        chk("t4 rng_ready in err", 32'(rng_ready), 32'd0);
        reseed_req = 1'b1;
        tick();
        reseed_req = 1'b0;
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("t4 busy ignored n=%0d", n), 32'(busy), 32'd0);
            chk($sformatf("t4 health sticky n=%0d", n), 32'(health_err), 32'd1);
            chk($sformatf("t4 rng_rst_n low n=%0d", n), 32'(rng_rst_n), 32'd0);
            tick();
        end
        do_reset("t4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
